dram_arbiter: RTL and testbench

//  Shares the single sdram_ctl port between two requesters.
//  - CPU port: single-word read/write, driven by mem_map.
//  - VGA port: 32-word burst read that fills the scanline buffer.

---
 rtl/dram_arb_pkg.sv | 21 ++
 rtl/dram_arb_rr.sv | 30 +++
 rtl/dram_arbiter.sv | 144 ++++++++++++++
 tb/tb_dram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the dram_arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_VGA
  } grant_t;

  localparam int BURST_LEN_DEF = 32;
  localparam int WAIT_CNT_W    = 10;

endpackage

// File: rtl/dram_arb_rr.sv
// 2-way request picker: round-robin between CPU and VGA, or fixed VGA priority
// when DRAM_ARB_VGA_PRIO_EN is defined. Latency: combinational.
// Backpressure: none; caller decides when to act on o_gnt.
// Ports: i_req[0]=CPU, i_req[1]=VGA; i_last = previous winner; o_gnt = winner.
module dram_arb_rr
  import dram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  grant_t     i_last,
  output grant_t     o_gnt
);

  always_comb begin
    o_gnt = GNT_CPU;
    case (i_req)
      2'b10: o_gnt = GNT_VGA;
      2'b11: begin
`ifdef DRAM_ARB_VGA_PRIO_EN
        // Display deadline: VGA always wins a tie, history ignored.
        o_gnt = GNT_VGA;
`else
        // Tie goes to whoever did not win last time.
        o_gnt = (i_last == GNT_VGA) ? GNT_CPU : GNT_VGA;
`endif
      end
      default: o_gnt = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one sdram_ctl port between a CPU word port and a VGA 32-word burst port.
// Latency: grant -> ISSUE (+1) -> WAIT (+2); done one cycle after dram_data_ready.
// Backpressure: requesters hold level req until done; no grant while dram_mem_ready=0.
// Ports: i_cpu_* single read/write, i_vga_* burst read, o_dram_*/i_dram_* to sdram_ctl,
//        o_*_done / o_err one-cycle completion pulses. Option: DRAM_ARB_VGA_PRIO_EN.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = 1023
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cpu_req,
  input  logic                          i_cpu_we,
  input  logic [ADDR_W-1:0]             i_cpu_addr,
  input  logic [DATA_W-1:0]             i_cpu_wdata,
  output logic [DATA_W-1:0]             o_cpu_rdata,
  output logic                          o_cpu_done,
  input  logic                          i_vga_req,
  input  logic [ADDR_W-1:0]             i_vga_addr,
  output logic [BURST_LEN*DATA_W-1:0]   o_vga_buf,
  output logic                          o_vga_done,
  output logic                          o_err,
  output logic                          o_dram_write_en,
  output logic [ADDR_W-1:0]             o_dram_addr,
  output logic [DATA_W-1:0]             o_dram_data_in,
  output logic                          o_dram_burst_en,
  output logic                          o_dram_refresh_data,
  input  logic [DATA_W-1:0]             i_dram_data_out,
  input  logic                          i_dram_data_ready,
  input  logic                          i_dram_mem_ready,
  input  logic [BURST_LEN*DATA_W-1:0]   i_dram_burst_buf
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

  arb_state_t r_state, w_state_nxt;
  grant_t     r_last, r_owner, w_gnt;

  logic                        r_we, r_burst, r_err;
  logic [ADDR_W-1:0]           r_addr;
  logic [DATA_W-1:0]           r_wdata;
  logic [WAIT_CNT_W-1:0]       r_wait_cnt;
  logic [DATA_W-1:0]           r_cpu_rdata;
  logic [BURST_LEN*DATA_W-1:0] r_vga_buf;
  logic                        w_start, w_timeout, w_active;

  dram_arb_rr u_rr (
    .i_req  ({i_vga_req, i_cpu_req}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_start   = i_dram_mem_ready && (i_cpu_req || i_vga_req);
  assign w_timeout = (r_wait_cnt == TIMEOUT_CNT);
  assign w_active  = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt         = r_state;
    o_dram_refresh_data = 1'b0;
    o_cpu_done          = 1'b0;
    o_vga_done          = 1'b0;
    o_err               = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        o_dram_refresh_data = 1'b1;
        w_state_nxt         = ST_WAIT;
      end
      ST_WAIT:  if (i_dram_data_ready || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: begin
        o_cpu_done  = (r_owner == GNT_CPU);
        o_vga_done  = (r_owner == GNT_VGA);
        o_err       = r_err;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched command stays registered after DONE; outputs are masked to 0 in IDLE
  // so the latch does not need clearing.
  assign o_dram_write_en = w_active & r_we;
  assign o_dram_burst_en = w_active & r_burst;
  assign o_dram_addr     = w_active ? r_addr  : '0;
  assign o_dram_data_in  = w_active ? r_wdata : '0;
  assign o_cpu_rdata     = r_cpu_rdata;
  assign o_vga_buf       = r_vga_buf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last      <= GNT_VGA;  // CPU wins the first tie
      r_owner     <= GNT_CPU;
      r_we        <= 1'b0;
      r_burst     <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_cpu_rdata <= '0;
      r_vga_buf   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_owner    <= w_gnt;
          r_err      <= 1'b0;
          r_wait_cnt <= '0;
          if (w_gnt == GNT_VGA) begin
            r_we    <= 1'b0;
            r_burst <= 1'b1;
            r_addr  <= i_vga_addr;
            r_wdata <= '0;
          end else begin
            r_we    <= i_cpu_we;
            r_burst <= 1'b0;
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
          end
        end
        ST_WAIT: begin
          if (i_dram_data_ready) begin
            if (r_owner == GNT_VGA) r_vga_buf   <= i_dram_burst_buf;
            else                    r_cpu_rdata <= i_dram_data_out;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_DONE: r_last <= r_owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a small behavioural sdram_ctl model.
// Latency: model answers a few cycles after the start strobe (or never when stalled).
// Backpressure: requesters hold req until done, drop it on the done cycle.
module tb_dram_arbiter;

  localparam logic [24:0] VB = {6'h1, 9'd7, 10'd32};

  typedef struct {
    bit           vga;
    bit           err;
    bit           chk;
    logic [511:0] dat;
  } exp_t;

  logic         clk, rst;
  logic         cpu_req, cpu_we, vga_req;
  logic [24:0]  cpu_addr, vga_addr;
  logic [15:0]  cpu_wdata, cpu_rdata;
  logic         cpu_done, vga_done, err;
  logic [511:0] vga_buf;
  logic         dram_write_en, dram_burst_en, dram_refresh_data;
  logic [24:0]  dram_addr;
  logic [15:0]  dram_data_in, dram_data_out;
  logic         dram_data_ready, dram_mem_ready;
  logic [511:0] dram_burst_buf;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    ref_cnt  = 0;
  exp_t  sb[$];
  exp_t  mon_e;
  bit    prev_ref, prev_dr;

  // sdram model state
  logic [15:0] mem [logic [24:0]];
  bit          stall;
  bit          pend, m_we, m_burst;
  int          cnt;
  logic [24:0] m_addr;
  logic [15:0] m_din;

  logic [46:0] outs;
  assign outs = {cpu_done, vga_done, err, dram_write_en, dram_addr,
                 dram_data_in, dram_burst_en, dram_refresh_data};

  dram_arbiter dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_cpu_req           (cpu_req),
    .i_cpu_we            (cpu_we),
    .i_cpu_addr          (cpu_addr),
    .i_cpu_wdata         (cpu_wdata),
    .o_cpu_rdata         (cpu_rdata),
    .o_cpu_done          (cpu_done),
    .i_vga_req           (vga_req),
    .i_vga_addr          (vga_addr),
    .o_vga_buf           (vga_buf),
    .o_vga_done          (vga_done),
    .o_err               (err),
    .o_dram_write_en     (dram_write_en),
    .o_dram_addr         (dram_addr),
    .o_dram_data_in      (dram_data_in),
    .o_dram_burst_en     (dram_burst_en),
    .o_dram_refresh_data (dram_refresh_data),
    .i_dram_data_out     (dram_data_out),
    .i_dram_data_ready   (dram_data_ready),
    .i_dram_mem_ready    (dram_mem_ready),
    .i_dram_burst_buf    (dram_burst_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Preloaded contents: addr 1 = 0x0009, burst region = {3{i[3:0]}}; writes override.
  function automatic logic [15:0] mem_rd(input logic [24:0] a);
    logic [24:0] off;
    if (mem.exists(a)) return mem[a];
    if (a == 25'd1) return 16'h0009;
    off = a - VB;
    if (a >= VB && off < 25'd32) return {4'h0, off[3:0], off[3:0], off[3:0]};
    return 16'h0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend            <= 1'b0;
      cnt             <= 0;
      dram_data_ready <= 1'b0;
      dram_data_out   <= '0;
      dram_burst_buf  <= '0;
    end else begin
      dram_data_ready <= 1'b0;
      if (dram_refresh_data) begin
        pend    <= 1'b1;
        cnt     <= 3;
        m_we    <= dram_write_en;
        m_burst <= dram_burst_en;
        m_addr  <= dram_addr;
        m_din   <= dram_data_in;
      end else if (stall) begin
        pend <= 1'b0;
      end else if (pend) begin
        if (cnt != 0) cnt <= cnt - 1;
        else begin
          pend            <= 1'b0;
          dram_data_ready <= 1'b1;
          if (m_we) mem[m_addr] = m_din;
          else if (m_burst)
            for (int i = 0; i < 32; i++) dram_burst_buf[i*16 +: 16] <= mem_rd(m_addr + 25'(i));
          else dram_data_out <= mem_rd(m_addr);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_ref = 1'b0;
      prev_dr  = 1'b0;
    end else begin
      if (dram_refresh_data) begin
        ref_cnt++;
        check_val("refresh_1cyc", prev_ref, 0);
      end
      if (prev_dr) check_val("done_after_ready", cpu_done | vga_done, 1);
      if (err) check_val("err_with_done", cpu_done | vga_done, 1);
      if (cpu_done || vga_done) begin
        check_val("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_val("done_who", vga_done, mon_e.vga);
          check_val("err", err, mon_e.err);
          if (mon_e.chk)
            check_val(mon_e.vga ? "vga_buf" : "cpu_rdata",
                      mon_e.vga ? vga_buf : {496'b0, cpu_rdata}, mon_e.dat);
        end
      end
      prev_ref = dram_refresh_data;
      prev_dr  = dram_data_ready;
    end
  end

  task automatic push(input bit vga, input bit e, input bit chk, input logic [511:0] dat);
    exp_t x;
    x.vga = vga; x.err = e; x.chk = chk; x.dat = dat;
    sb.push_back(x);
  endtask

  task automatic run_txn(input bit vga, input bit we, input logic [24:0] addr,
                         input logic [15:0] wd, input bit chk_cmd, output int lat);
    bit got  = 1'b0;
    bit seen = 1'b0;
    bit bad  = 1'b0;
    int ref_at = 0;
    lat = -1;
    @(negedge clk);
    if (vga) begin
      vga_req = 1'b1; vga_addr = addr;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (dram_refresh_data && !seen) begin seen = 1'b1; ref_at = k; end
      if (seen && ((dram_write_en !== we) || (dram_burst_en !== vga))) bad = 1'b1;
      got = vga ? vga_done : cpu_done;
      if (got) lat = k - ref_at;
    end
    if (vga) vga_req = 1'b0; else cpu_req = 1'b0;
    check_val(vga ? "vga_done_seen" : "cpu_done_seen", got, 1);
    if (chk_cmd) check_val("cmd_hold", bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [511:0] exp_vga;
  int lat, lat2, r0;

  initial begin
    rst = 1'b1; stall = 1'b0; dram_mem_ready = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] n;
      n = i[3:0];
      exp_vga[i*16 +: 16] = {4'h0, n, n, n};
    end

    repeat (3) @(negedge clk);
    check_val("reset_outs", outs, 0);
    check_val("reset_rdata", cpu_rdata, 0);
    rst = 1'b0;

    // No grant while the controller is not ready; a dropped req is ignored.
    r0 = ref_cnt;
    cpu_req = 1'b1; cpu_addr = 25'd1;
    repeat (6) @(negedge clk);
    check_val("no_grant_not_ready", ref_cnt - r0, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    dram_mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("dropped_req_ignored", ref_cnt - r0, 0);

    // 1: CPU read of preloaded word
    r0 = ref_cnt;
    push(0, 0, 1, 512'h0009);
    run_txn(0, 0, 25'd1, 16'h0, 1, lat);
    repeat (3) @(negedge clk);
    check_val("t1_refresh_count", ref_cnt - r0, 1);
    check_val("rdata_hold", cpu_rdata, 16'h0009);
    check_val("idle_cmd_zero", outs, 0);

    // 2: CPU write
    push(0, 0, 0, 512'h0);
    run_txn(0, 1, 25'd0, 16'hABAB, 1, lat);
    @(negedge clk);
    check_val("t2_mem0", mem_rd(25'd0), 16'hABAB);

    // 4: VGA burst
    push(1, 0, 1, exp_vga);
    run_txn(1, 0, VB, 16'h0, 1, lat);
    check_val("vga_addr", m_addr, VB);
    check_val("vga_burst_en", m_burst, 1);

    // 3: simultaneous requests straight after reset
    do_reset();
    check_val("rst_vga_buf", vga_buf, 0);
    r0 = ref_cnt;
`ifdef DRAM_ARB_VGA_PRIO_EN
    push(1, 0, 1, exp_vga);
    push(0, 0, 1, 512'hABAB);
`else
    push(0, 0, 1, 512'hABAB);
    push(1, 0, 1, exp_vga);
`endif
    fork
      run_txn(0, 0, 25'd0, 16'h0, 0, lat);
      run_txn(1, 0, VB, 16'h0, 0, lat2);
    join
    @(negedge clk);
    check_val("t3_refresh_count", ref_cnt - r0, 2);

    // 5: timeout abort, then a normal transaction
    stall = 1'b1;
    push(0, 1, 0, 512'h0);
    run_txn(0, 0, 25'd1, 16'h0, 1, lat);
    check_val("timeout_lat", (lat >= 1023 && lat <= 1027), 1);
    stall = 1'b0;
    push(0, 0, 1, 512'h0009);
    run_txn(0, 0, 25'd1, 16'h0, 1, lat);

    // 6: reset in the middle of WAIT
    @(negedge clk);
    stall = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'd1;
    repeat (6) @(negedge clk);
    check_val("t6_in_wait_we", dram_burst_en | dram_write_en, 0);
    check_val("t6_in_wait_addr", dram_addr, 25'd1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_wait_outs", outs, 0);
    check_val("rst_mid_wait_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    push(0, 0, 1, 512'h0009);
    run_txn(0, 0, 25'd1, 16'h0, 1, lat);

    repeat (3) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
